// File: rtl/accel_host_loader_if.sv
// accel_host_loader_if: host command stream in, status/readback stream out
interface accel_host_loader_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/accel_host_loader.sv
// accel_host_loader: host command front end loading imem/dmem, running the core and streaming dmem back
module accel_host_loader #(
    parameter int NUM_SIZE         = 16,
    parameter int NUM_INSTRUCTIONS = 16,
    parameter int WORDS_IN_MEMORY  = 32,
    parameter int MAX_RUN_CYCLES   = 1024,
    localparam int IA = $clog2(NUM_INSTRUCTIONS),
    localparam int DA = $clog2(WORDS_IN_MEMORY),
    localparam int AW = IA > DA ? IA : DA,
    localparam int CW = $clog2(MAX_RUN_CYCLES)
) (
    input  logic                clk,
    input  logic                rst,
    accel_host_loader_if.slave  host,
    output logic                instr_we,
    output logic [IA-1:0]       instr_addr,
    output logic [31:0]         instr_wdata,
    output logic                mem_we,
    output logic [DA-1:0]       mem_addr,
    output logic [NUM_SIZE-1:0] mem_wdata,
    input  logic [NUM_SIZE-1:0] mem_rdata,
    output logic                accel_run,
    input  logic                accel_halted,
    output logic                busy,
    output logic                cmd_err
);
    typedef enum logic [2:0] {IDLE, LD_INSTR, LD_DATA, RUN, RD_ADDR, RD_WAIT, RD_OUT, STATUS} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    count_q, count_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          cmd_err_q, cmd_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        cmd_err_d  = cmd_err_q;
        case (state_q)
            IDLE: if (host.in_valid) begin
                addr_d  = host.in_data[8 +: AW];
                count_d = host.in_data[7:0];
                cnt_d   = '0;
                case (host.in_data[31:28])
                    4'd1:    state_d = host.in_data[7:0] != 8'd0 ? LD_INSTR : IDLE;
                    4'd2:    state_d = host.in_data[7:0] != 8'd0 ? LD_DATA : IDLE;
                    4'd3:    state_d = RUN;
                    4'd4:    state_d = host.in_data[7:0] != 8'd0 ? RD_ADDR : IDLE;
                    default: cmd_err_d = 1'b1;
                endcase
            end
            LD_INSTR, LD_DATA: if (host.in_valid) begin
                addr_d  = addr_q + 1'b1;
                count_d = count_q - 1'b1;
                state_d = count_q == 8'd1 ? IDLE : state_q;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // halt has priority: the timeout flag only reports a core that never halted
                if (accel_halted || cnt_q == CW'(MAX_RUN_CYCLES - 1)) begin
                    state_d    = STATUS;
                    out_data_d = {4'h3, 11'b0, ~accel_halted, 16'(cnt_q)};
                end
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: begin
                state_d    = RD_OUT;
                out_data_d = {4'h4, 12'b0, 16'(mem_rdata)};
            end
            RD_OUT: if (host.out_ready) begin
                addr_d  = addr_q + 1'b1;
                count_d = count_q - 1'b1;
                state_d = count_q == 8'd1 ? IDLE : RD_ADDR;
            end
            STATUS: state_d = host.out_ready ? IDLE : STATUS;
            default: state_d = IDLE;
        endcase
    end

    assign host.in_ready  = state_q inside {IDLE, LD_INSTR, LD_DATA};
    assign host.out_valid = state_q inside {RD_OUT, STATUS};
    assign host.out_data  = out_data_q;
    assign instr_we       = state_q == LD_INSTR && host.in_valid;
    assign mem_we         = state_q == LD_DATA && host.in_valid;
    assign instr_addr     = addr_q[IA-1:0];
    assign mem_addr       = addr_q[DA-1:0];
    assign instr_wdata    = host.in_data;
    assign mem_wdata      = host.in_data[NUM_SIZE-1:0];
    assign accel_run      = state_q == RUN;
    assign busy           = state_q != IDLE;
    assign cmd_err        = cmd_err_q;
endmodule
